// File: rtl/ras_pkg.sv
// Shared fetch-predictor types for the return address stack and its checkpoints.
package ras_pkg;

  localparam int unsigned RAS_ENTRIES     = 16;
  localparam int unsigned LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES);

  typedef logic [37:0]                  PC38_t;
  typedef logic [LOG_RAS_ENTRIES-1:0]   RAS_idx_t;
  typedef logic [LOG_RAS_ENTRIES:0]     RAS_count_t;

  typedef struct packed {
    RAS_idx_t   index;
    RAS_count_t count;
  } RAS_ckpt_t;

endpackage

// File: rtl/ras.sv
// Return address stack: push on call, pop on return, replace top on RET_L,
// checkpoint restore on mispredict. Define RAS_REPAIR_TOP_EN to also repair the restored top entry.
module ras
  import ras_pkg::*;
#(
  parameter int unsigned RAS_ENTRIES = ras_pkg::RAS_ENTRIES,
  parameter logic [37:0] INIT_PC38   = 38'h0,
  localparam int unsigned LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES)
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       link_valid,
  input  logic [37:0]                link_pc38,
  input  logic                       ret_valid,
  output logic [37:0]                ret_pc38,
  output logic                       ret_empty,
  output logic [LOG_RAS_ENTRIES-1:0] ras_index,
  output logic [LOG_RAS_ENTRIES:0]   ras_count,
  input  logic                       update_valid,
  input  logic [LOG_RAS_ENTRIES-1:0] update_ras_index,
  input  logic [LOG_RAS_ENTRIES:0]   update_ras_count,
  input  logic [37:0]                update_top_pc38
);

  localparam logic [LOG_RAS_ENTRIES:0] FULL_COUNT = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);

  logic [37:0]                stack_q [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0] ptr_q, ptr_d;
  logic [LOG_RAS_ENTRIES:0]   count_q, count_d;
  logic                       wr_en;
  logic [LOG_RAS_ENTRIES-1:0] wr_addr;
  logic [37:0]                wr_data;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    wr_data = link_pc38;
    if (update_valid) begin
      ptr_d   = update_ras_index;
      count_d = update_ras_count;
`ifdef RAS_REPAIR_TOP_EN
      wr_en   = 1'b1;
      wr_addr = update_ras_index;
      wr_data = update_top_pc38;
`endif
    end else if (link_valid && ret_valid) begin
      // Pop-then-push collapses to overwriting the current top in place.
      wr_en   = 1'b1;
      count_d = (count_q == '0) ? (LOG_RAS_ENTRIES+1)'(1) : count_q;
    end else if (link_valid) begin
      ptr_d   = ptr_q + 1'b1;
      wr_en   = 1'b1;
      wr_addr = ptr_q + 1'b1;
      count_d = (count_q == FULL_COUNT) ? count_q : count_q + 1'b1;
    end else if (ret_valid && count_q != '0) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < RAS_ENTRIES; i++) stack_q[i] <= INIT_PC38;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (wr_en) stack_q[wr_addr] <= wr_data;
    end
  end

  assign ret_pc38  = stack_q[ptr_q];
  assign ret_empty = (count_q == '0);
  assign ras_index = ptr_q;
  assign ras_count = count_q;

`ifndef RAS_REPAIR_TOP_EN
  logic unused_top;
  assign unused_top = ^update_top_pc38;
`endif

endmodule

// File: tb/tb_ras.sv
// Scoreboard bench for ras: a reference stack model queues expected outputs per driven cycle.
module tb_ras;
  import ras_pkg::*;

  typedef struct {
    logic [37:0] pc;
    logic        empty;
    logic [3:0]  idx;
    logic [4:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_valid = 1'b0, ret_valid = 1'b0, update_valid = 1'b0;
  logic [37:0] link_pc38 = '0, update_top_pc38 = '0, ret_pc38;
  logic        ret_empty;
  logic [3:0]  ras_index, update_ras_index = '0;
  logic [4:0]  ras_count, update_ras_count = '0;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];

  logic [37:0] m_stack [16];
  int          m_ptr, m_cnt;

  ras #(.RAS_ENTRIES(16), .INIT_PC38(38'h0)) dut (
    .CLK(clk), .nRST(rst_n),
    .link_valid(link_valid), .link_pc38(link_pc38), .ret_valid(ret_valid),
    .ret_pc38(ret_pc38), .ret_empty(ret_empty), .ras_index(ras_index), .ras_count(ras_count),
    .update_valid(update_valid), .update_ras_index(update_ras_index),
    .update_ras_count(update_ras_count), .update_top_pc38(update_top_pc38)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pc    = m_stack[m_ptr];
    e.empty = (m_cnt == 0);
    e.idx   = 4'(m_ptr);
    e.cnt   = 5'(m_cnt);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_stack[i] = 38'h0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_pc"},    64'(ret_pc38),  64'(e.pc));
    check({tag, "_empty"}, 64'(ret_empty), 64'(e.empty));
    check({tag, "_idx"},   64'(ras_index), 64'(e.idx));
    check({tag, "_cnt"},   64'(ras_count), 64'(e.cnt));
  endtask

  // Drive one cycle, advance the model, queue its prediction, then compare after the edge.
  task automatic step(input string tag, input logic lk, input logic [37:0] lpc, input logic rt,
                      input logic up, input int uidx, input int ucnt, input logic [37:0] utop);
    link_valid = lk; link_pc38 = lpc; ret_valid = rt;
    update_valid = up; update_ras_index = 4'(uidx); update_ras_count = 5'(ucnt);
    update_top_pc38 = utop;
    if (up) begin
      m_ptr = uidx;
      m_cnt = ucnt;
`ifdef RAS_REPAIR_TOP_EN
      m_stack[uidx] = utop;
`endif
    end else if (lk && rt) begin
      m_stack[m_ptr] = lpc;
      if (m_cnt == 0) m_cnt = 1;
    end else if (lk) begin
      m_ptr = (m_ptr + 1) % 16;
      m_stack[m_ptr] = lpc;
      if (m_cnt < 16) m_cnt++;
    end else if (rt && m_cnt > 0) begin
      m_ptr = (m_ptr + 15) % 16;
      m_cnt--;
    end
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    compare_out(tag);
    link_valid = 1'b0; ret_valid = 1'b0; update_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_pc",    64'(ret_pc38),  64'h0);
    check("rst_empty", 64'(ret_empty), 64'd1);
    check("rst_idx",   64'(ras_index), 64'd0);
    check("rst_cnt",   64'(ras_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    do_reset();

    step("pop_empty", 0, 38'h0, 1, 0, 0, 0, 38'h0);
    step("push100", 1, 38'h100, 0, 0, 0, 0, 38'h0);
    step("push200", 1, 38'h200, 0, 0, 0, 0, 38'h0);
    check("push2_pc", 64'(ret_pc38), 64'h200);
    check("push2_idx", 64'(ras_index), 64'd2);
    step("pop1", 0, 38'h0, 1, 0, 0, 0, 38'h0);
    check("pop1_pc", 64'(ret_pc38), 64'h100);
    check("pop1_cnt", 64'(ras_count), 64'd1);

    do_reset();
    for (int v = 1; v <= 17; v++) step("fill", 1, 38'(v), 0, 0, 0, 0, 38'h0);
    check("full_cnt", 64'(ras_count), 64'd16);
    check("full_idx", 64'(ras_index), 64'd1);
    check("full_pc",  64'(ret_pc38),  64'd17);
    for (int k = 0; k < 16; k++) begin
      check("drain_top", 64'(ret_pc38), 64'(17 - k));
      step("drain", 0, 38'h0, 1, 0, 0, 0, 38'h0);
    end
    check("drained_empty", 64'(ret_empty), 64'd1);

    do_reset();
    step("pushA", 1, 38'hA, 0, 0, 0, 0, 38'h0);
    step("pushB", 1, 38'hB, 0, 0, 0, 0, 38'h0);
    step("retl", 1, 38'hC, 1, 0, 0, 0, 38'h0);
    check("retl_pc",  64'(ret_pc38),  64'hC);
    check("retl_idx", 64'(ras_index), 64'd2);
    check("retl_cnt", 64'(ras_count), 64'd2);
    step("retl_empty", 0, 38'h0, 1, 0, 0, 0, 38'h0);
    step("retl_empty2", 0, 38'h0, 1, 0, 0, 0, 38'h0);
    step("retl_from0", 1, 38'hD, 1, 0, 0, 0, 38'h0);

    begin
      RAS_ckpt_t ck;
      step("push3", 1, 38'h33, 0, 0, 0, 0, 38'h0);
      step("set_ck", 0, 38'h0, 0, 1, 3, 3, 38'h33);
      ck.index = ras_index;
      ck.count = ras_count;
      check("ck_idx", 64'(ck.index), 64'd3);
      step("pushX", 1, 38'h5A5, 0, 0, 0, 0, 38'h0);
      step("pushY", 1, 38'h6B6, 0, 0, 0, 0, 38'h0);
      step("restore", 1, 38'h777, 0, 1, 3, 3, 38'h33);
      check("restore_idx", 64'(ras_index), 64'd3);
      check("restore_cnt", 64'(ras_count), 64'd3);
    end

    step("pushOver3", 1, 38'h999, 1, 0, 0, 0, 38'h0);
    step("repair", 0, 38'h0, 0, 1, 3, 3, 38'hABC);
`ifdef RAS_REPAIR_TOP_EN
    check("repair_pc", 64'(ret_pc38), 64'hABC);
`else
    check("norepair_pc", 64'(ret_pc38), 64'h999);
`endif

    for (int n = 0; n < 300; n++) begin
      logic up;
      up = ($urandom_range(0, 9) == 0);
      step("rand", 1'($urandom), 38'({$urandom, $urandom}), 1'($urandom), up,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 16)), 38'({$urandom, $urandom}));
    end

    step("pre_midrst", 1, 38'h1234, 0, 0, 0, 0, 38'h0);
    @(negedge clk);
    link_valid = 1'b1; link_pc38 = 38'h4321;
    do_reset();
    link_valid = 1'b0;
    step("post_rst", 0, 38'h0, 0, 0, 0, 0, 38'h0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
